// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LEN0  = 3'd1,
        ST_LEN1  = 3'd2,
        ST_DATA  = 3'd3,
        ST_CHECK = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    // Width of the word-count field at the head of the frame
    localparam int LEN_W = 16;

    // Byte-lane mapping: lane k of a word occupies bits [LANE_W*k +: LANE_W],
    // so the first byte of the little-endian stream lands in bits [7:0].
    localparam int         LANE_W    = 8;
    localparam logic [1:0] LAST_LANE = 2'd3;

    // Place one byte into its lane of a 32-bit word, leaving other lanes alone
    function automatic logic [31:0] lane_insert(input logic [31:0] word,
                                                input logic [1:0]  lane,
                                                input logic [7:0]  data);
        logic [31:0] w;
        w = word;
        w[LANE_W*lane +: LANE_W] = data;
        return w;
    endfunction

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs accepted stream bytes into 32-bit little-endian words and emits a
// one-cycle word_valid pulse with the completed word the cycle after the
// fourth byte is accepted.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_in,
    output logic        last_lane,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;
    logic [31:0] assembled_s;

    // Next-state logic: insert the byte into its lane, release on the last lane
    always_comb begin
        byte_idx_d   = byte_idx_q;
        shift_d      = shift_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        assembled_s  = lane_insert(shift_q, byte_idx_q, byte_in);
        if (clr) begin
            byte_idx_d = 2'd0;
            shift_d    = 32'h0000_0000;
        end else if (byte_valid) begin
            if (byte_idx_q == LAST_LANE) begin
                word_d       = assembled_s;
                word_valid_d = 1'b1;
                byte_idx_d   = 2'd0;
                shift_d      = 32'h0000_0000;
            end else begin
                byte_idx_d = byte_idx_q + 2'd1;
                shift_d    = assembled_s;
            end
        end else begin
            byte_idx_d = byte_idx_q;
        end
    end

    // Packer state registers; reset discards any partial word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            byte_idx_q   <= 2'd0;
            shift_q      <= 32'h0000_0000;
            word_q       <= 32'h0000_0000;
            word_valid_q <= 1'b0;
        end else begin
            byte_idx_q   <= byte_idx_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign last_lane  = (byte_idx_q == LAST_LANE);
    assign word       = word_q;
    assign word_valid = word_valid_q;

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction-memory loader: parses a framed byte stream
// (16-bit word count, little-endian words, XOR checksum), writes each word
// to the instruction memory and holds the CPU in reset until a clean load.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold
);

    localparam int WIDX_W = $clog2(DEPTH + 1);

    state_e            state_q, state_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [WIDX_W-1:0] word_idx_q, word_idx_d;
    logic [7:0]        csum_q, csum_d;
    logic              in_ready_q, in_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic              cpu_hold_q, cpu_hold_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    logic              accept_s;
    logic              pack_clr_s;
    logic              pack_valid_s;
    logic              last_lane_s;
    logic [LEN_W-1:0]  n_s;
    logic              accepting_s;

    assign accept_s     = in_valid && in_ready_q;
    assign n_s          = {in_data, len_q[7:0]};
    assign pack_valid_s = accept_s && (state_q == ST_DATA);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (pack_clr_s),
        .byte_valid (pack_valid_s),
        .byte_in    (in_data),
        .last_lane  (last_lane_s),
        .word       (mem_wdata),
        .word_valid (mem_we)
    );

    // FSM next-state, counters, checksum and flag updates
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        word_idx_d = word_idx_q;
        csum_d     = csum_q;
        error_d    = error_q;
        cpu_hold_d = cpu_hold_q;
        mem_addr_d = mem_addr_q;
        pack_clr_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (load_start) begin
                    state_d    = ST_LEN0;
                    error_d    = 1'b0;
                    csum_d     = 8'h00;
                    word_idx_d = '0;
                    pack_clr_s = 1'b1;
                    cpu_hold_d = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_LEN0: begin
                if (accept_s) begin
                    len_d   = {8'h00, in_data};
                    state_d = ST_LEN1;
                end else begin
                    state_d = ST_LEN0;
                end
            end
            ST_LEN1: begin
                if (accept_s) begin
                    len_d = n_s;
                    if (n_s > LEN_W'(DEPTH)) begin
                        state_d = ST_DONE;
                        error_d = 1'b1;
                    end else if (n_s == 16'h0000) begin
                        state_d = ST_CHECK;
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_LEN1;
                end
            end
            ST_DATA: begin
                if (accept_s) begin
                    csum_d = csum_q ^ in_data;
                    if (last_lane_s) begin
                        // Capture this word's address before word_idx advances
                        mem_addr_d = ADDR_W'({word_idx_q, 2'b00});
                        word_idx_d = word_idx_q + WIDX_W'(1);
                        if ((LEN_W'(word_idx_q) + 16'd1) == len_q) begin
                            state_d = ST_CHECK;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    state_d = ST_DONE;
                    if (in_data == csum_q) begin
                        error_d    = 1'b0;
                        cpu_hold_d = 1'b0;
                    end else begin
                        error_d    = 1'b1;
                        cpu_hold_d = 1'b1;
                    end
                end else begin
                    state_d = ST_CHECK;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                cpu_hold_d = 1'b1;
            end
        endcase

        accepting_s = (state_d == ST_LEN0) || (state_d == ST_LEN1) ||
                      (state_d == ST_DATA) || (state_d == ST_CHECK);
        in_ready_d  = accepting_s;
        busy_d      = accepting_s;
        done_d      = (state_d == ST_DONE);
    end

    // FSM and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            word_idx_q <= '0;
            csum_q     <= 8'h00;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            cpu_hold_q <= 1'b1;
            mem_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            word_idx_q <= word_idx_d;
            csum_q     <= csum_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            cpu_hold_q <= cpu_hold_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    assign in_ready = in_ready_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign error    = error_q;
    assign cpu_hold = cpu_hold_q;
    assign mem_addr = mem_addr_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader.
module tb_imem_loader;

    logic        clk;
    logic        rst_n;
    logic        load_start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        busy;
    logic        done;
    logic        error;
    logic        cpu_hold;

    imem_loader #(.DEPTH(64), .ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .cpu_hold   (cpu_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    // Capture every write strobe mid-cycle
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_wdata);
        end
    end

    typedef struct {
        string             name;
        int                nbytes;
        logic [0:11][7:0]  bytes;
        int                nwr;
        logic [0:1][31:0]  words;
        logic              exp_error;
        logic              exp_hold;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the byte was accepted
    task automatic send_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_data  = b;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic run_frame(input int i, input bit gappy);
        vec_t v;
        int   p;
        v = vecs[i];
        wr_addr_q.delete();
        wr_data_q.delete();
        if (gappy) begin
            // Early bytes are ignored, then start collides with a valid byte
            in_valid = 1'b1;
            in_data  = 8'h02;
            repeat (3) begin
                @(negedge clk);
                chk("early_ready", {31'd0, in_ready}, 32'd0);
            end
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
            in_valid   = 1'b0;
        end else begin
            load_start = 1'b1;
            @(negedge clk);
            load_start = 1'b0;
        end
        chk({v.name, "_busy"}, {31'd0, busy}, 32'd1);
        chk({v.name, "_hold_start"}, {31'd0, cpu_hold}, 32'd1);
        chk({v.name, "_done_clr"}, {31'd0, done}, 32'd0);
        chk({v.name, "_err_clr"}, {31'd0, error}, 32'd0);
        for (p = 0; p < v.nbytes; p++) begin
            if (gappy) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                if (p == 4) begin
                    load_start = 1'b1;
                    @(negedge clk);
                    load_start = 1'b0;
                end
            end
            send_byte(v.bytes[p]);
            if (p >= 5 && ((p - 5) % 4) == 0 && ((p - 5) / 4) < v.nwr) begin
                chk({v.name, "_we_latency"}, {31'd0, mem_we}, 32'd1);
                chk({v.name, "_addr_latency"}, mem_addr, 32'((p - 5) / 4 * 4));
            end
        end
        chk({v.name, "_done"}, {31'd0, done}, 32'd1);
        chk({v.name, "_error"}, {31'd0, error}, {31'd0, v.exp_error});
        chk({v.name, "_hold"}, {31'd0, cpu_hold}, {31'd0, v.exp_hold});
        chk({v.name, "_busy_end"}, {31'd0, busy}, 32'd0);
        repeat (3) @(negedge clk);
        chk({v.name, "_nwr"}, 32'(wr_addr_q.size()), 32'(v.nwr));
        for (int k = 0; k < v.nwr; k++) begin
            if (k < wr_addr_q.size()) begin
                chk({v.name, "_addr"}, wr_addr_q[k], 32'(k * 4));
                chk({v.name, "_wdata"}, wr_data_q[k], v.words[k]);
            end
        end
        chk({v.name, "_done_hold"}, {31'd0, done}, 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        chk({tag, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({tag, "_mem_addr"}, mem_addr, 32'd0);
        chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_error"}, {31'd0, error}, 32'd0);
        chk({tag, "_cpu_hold"}, {31'd0, cpu_hold}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"normal", 11,
                    {8'h02, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00, 8'hF0, 8'h00},
                    2, {32'h00700113, 32'h00208133}, 1'b0, 1'b0};
        vecs[1] = '{"badck", 11,
                    {8'h02, 8'h00, 8'h13, 8'h01, 8'h70, 8'h00, 8'h33, 8'h81, 8'h20, 8'h00, 8'hF1, 8'h00},
                    2, {32'h00700113, 32'h00208133}, 1'b1, 1'b1};
        vecs[2] = '{"empty", 3,
                    {8'h00, 8'h00, 8'h00, 72'h0},
                    0, {32'h0, 32'h0}, 1'b0, 1'b0};
        vecs[3] = '{"oneword", 7,
                    {8'h01, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00, 40'h0},
                    1, {32'hDDCCBBAA, 32'h0}, 1'b0, 1'b0};
        vecs[4] = '{"overflow", 2,
                    {8'h41, 8'h00, 80'h0},
                    0, {32'h0, 32'h0}, 1'b1, 1'b1};
        vecs[5] = '{"emptybad", 3,
                    {8'h00, 8'h00, 8'h5A, 72'h0},
                    0, {32'h0, 32'h0}, 1'b1, 1'b1};

        rst_n      = 1'b0;
        load_start = 1'b0;
        in_data    = 8'h00;
        in_valid   = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(i, 1'b0);
            if (i == 4) begin
                // After a length overflow, further bytes are refused
                in_valid = 1'b1;
                in_data  = 8'h13;
                repeat (3) begin
                    @(negedge clk);
                    chk("overflow_ready", {31'd0, in_ready}, 32'd0);
                end
                in_valid = 1'b0;
                chk("overflow_nowr", 32'(wr_addr_q.size()), 32'd0);
            end
        end

        // Gappy stream with early bytes, start collision and ignored mid-load start
        run_frame(0, 1'b1);

        // Full-depth load: 64 words, byte j of the payload is j
        wr_addr_q.delete();
        wr_data_q.delete();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'h40);
        send_byte(8'h00);
        for (int j = 0; j < 256; j++) send_byte(8'(j));
        send_byte(8'h00);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_error", {31'd0, error}, 32'd0);
        chk("full_hold", {31'd0, cpu_hold}, 32'd0);
        repeat (2) @(negedge clk);
        chk("full_nwr", 32'(wr_addr_q.size()), 32'd64);
        if (wr_addr_q.size() == 64) begin
            chk("full_last_addr", wr_addr_q[63], 32'h0000_00FC);
            chk("full_last_data", wr_data_q[63], 32'hFFFEFDFC);
            chk("full_mid_data", wr_data_q[10], 32'h2B2A2928);
        end

        // Reset in the middle of DATA, then a clean reload
        run_frame(0, 1'b0);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h13);
        send_byte(8'h01);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_values("midreset");
        rst_n = 1'b1;
        @(negedge clk);
        run_frame(0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
